// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl memory interface block.
// The ERR state exists only when MEM_CTRL_TIMEOUT_EN is defined.
package mem_ctrl_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3
`ifdef MEM_CTRL_TIMEOUT_EN
      ,
      ST_ERR   = 3'd4
`endif
   } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for outstanding memory accesses; expired flags the last
// permitted cycle so the controller can leave on the following edge.
module mem_timeout_ctr #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic expired
);

   logic [7:0] cnt_r;

   // Count cycles while an access is outstanding, restart when idle.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_r <= 8'd0;
      end else if (en) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = en && (cnt_r == (LIMIT - 8'd1));

endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer between the multicycle core FSM and a req/ack memory.
// Optional access timeout with sticky error: define MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
   parameter logic [31:0] RESET_INSTR    = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic        is_fetch,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [31:0] data,
   output logic        stall,
   output logic        err
);

   state_e state_r;
   state_e state_nxt_s;
   logic   fetch_r;
   logic   busy_s;

   assign busy_s = (state_r == ST_READ) || (state_r == ST_WRITE);

`ifdef MEM_CTRL_TIMEOUT_EN
   logic expired_s;

   mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
      .clk     (clk),
      .reset   (reset),
      .en      (busy_s),
      .clr     (!busy_s),
      .expired (expired_s)
   );
`else
   // Constant-folds to zero; keeps TIMEOUT_CYCLES referenced in this build.
   assign err = 1'b0 & (TIMEOUT_CYCLES == 8'd0);
`endif

   // Next-state decode; an ack in the same cycle as expiry still completes.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (wr_req) begin
               state_nxt_s = ST_WRITE;
            end else if (rd_req) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ, ST_WRITE: begin
            if (mem_ack) begin
               state_nxt_s = ST_DONE;
`ifdef MEM_CTRL_TIMEOUT_EN
            end else if (expired_s) begin
               state_nxt_s = ST_ERR;
`endif
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
`ifdef MEM_CTRL_TIMEOUT_EN
         ST_ERR:  state_nxt_s = ST_ERR;
`endif
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, latched request fields and returned-data registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
         fetch_r   <= 1'b0;
         instr     <= RESET_INSTR;
         data      <= 32'h0000_0000;
`ifdef MEM_CTRL_TIMEOUT_EN
         err       <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         mem_req <= (state_nxt_s == ST_READ) || (state_nxt_s == ST_WRITE);
         mem_we  <= (state_nxt_s == ST_WRITE);
`ifdef MEM_CTRL_TIMEOUT_EN
         err     <= err || (state_nxt_s == ST_ERR);
`endif
         if ((state_r == ST_IDLE) && (wr_req || rd_req)) begin
            mem_addr <= addr;
         end else begin
            mem_addr <= mem_addr;
         end
         if ((state_r == ST_IDLE) && wr_req) begin
            mem_wdata <= wdata;
         end else begin
            mem_wdata <= mem_wdata;
         end
         if ((state_r == ST_IDLE) && !wr_req && rd_req) begin
            fetch_r <= is_fetch;
         end else begin
            fetch_r <= fetch_r;
         end
         if ((state_r == ST_READ) && mem_ack && fetch_r) begin
            instr <= mem_rdata;
         end else begin
            instr <= instr;
         end
         if ((state_r == ST_READ) && mem_ack && !fetch_r) begin
            data <= mem_rdata;
         end else begin
            data <= data;
         end
      end
   end

`ifdef MEM_CTRL_TIMEOUT_EN
   assign stall = ((state_r == ST_IDLE) && (rd_req || wr_req)) || busy_s ||
                  (state_r == ST_ERR);
`else
   assign stall = ((state_r == ST_IDLE) && (rd_req || wr_req)) || busy_s;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: per-cycle vector table plus reset/timeout sequences.
module tb_mem_ctrl;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] Z   = 32'h0;
   localparam logic [31:0] I1  = 32'h00500113;
   localparam logic [31:0] DB  = 32'hDEADBEEF;
   localparam logic [31:0] WD  = 32'h12345678;
   localparam logic [31:0] CF  = 32'hCAFEF00D;

   logic        clk = 1'b0;
   logic        reset, rd_req, wr_req, is_fetch, mem_ack;
   logic [31:0] addr, wdata, mem_rdata;
   logic        mem_req, mem_we, stall, err;
   logic [31:0] mem_addr, mem_wdata, instr, data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rd, wr, fet;
      logic [31:0] a, wd;
      logic        ack;
      logic [31:0] rdat;
      logic        e_stall, e_req, e_we;
      logic [31:0] e_addr, e_wdata, e_instr, e_data;
   } vec_t;

   vec_t vecs [20];

   mem_ctrl #(.TIMEOUT_CYCLES(8'd4), .RESET_INSTR(NOP)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .is_fetch  (is_fetch),
      .addr      (addr),
      .wdata     (wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .instr     (instr),
      .data      (data),
      .stall     (stall),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic f, input logic [31:0] a,
                        input logic [31:0] d, input logic k, input logic [31:0] rd);
      rd_req = r; wr_req = w; is_fetch = f; addr = a; wdata = d; mem_ack = k; mem_rdata = rd;
   endtask

   initial begin
      // Each row is one cycle: inputs driven, then outputs expected in that same cycle.
      vecs[0]  = '{1'b1,1'b0,1'b1,32'h10,Z,1'b0,Z,        1'b1,1'b0,1'b0,Z,     Z, NOP,Z};
      vecs[1]  = '{1'b1,1'b0,1'b1,32'h10,Z,1'b1,I1,       1'b1,1'b1,1'b0,32'h10,Z, NOP,Z};
      vecs[2]  = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h10,Z, I1, Z};
      vecs[3]  = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h10,Z, I1, Z};
      vecs[4]  = '{1'b1,1'b0,1'b0,32'h40,Z,1'b0,Z,        1'b1,1'b0,1'b0,32'h10,Z, I1, Z};
      vecs[5]  = '{1'b1,1'b0,1'b0,32'h40,Z,1'b0,Z,        1'b1,1'b1,1'b0,32'h40,Z, I1, Z};
      vecs[6]  = '{1'b1,1'b0,1'b0,32'h40,Z,1'b0,Z,        1'b1,1'b1,1'b0,32'h40,Z, I1, Z};
      vecs[7]  = '{1'b1,1'b0,1'b0,32'h40,Z,1'b0,Z,        1'b1,1'b1,1'b0,32'h40,Z, I1, Z};
      vecs[8]  = '{1'b1,1'b0,1'b0,32'h40,Z,1'b1,DB,       1'b1,1'b1,1'b0,32'h40,Z, I1, Z};
      vecs[9]  = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h40,Z, I1, DB};
      vecs[10] = '{1'b0,1'b1,1'b0,32'h44,WD,1'b0,Z,       1'b1,1'b0,1'b0,32'h40,Z, I1, DB};
      vecs[11] = '{1'b0,1'b1,1'b0,32'h44,WD,1'b1,32'hAAAAAAAA, 1'b1,1'b1,1'b1,32'h44,WD,I1,DB};
      vecs[12] = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h44,WD,I1, DB};
      vecs[13] = '{1'b1,1'b1,1'b1,32'h80,CF,1'b0,Z,       1'b1,1'b0,1'b0,32'h44,WD,I1, DB};
      vecs[14] = '{1'b1,1'b1,1'b1,32'h80,CF,1'b0,Z,       1'b1,1'b1,1'b1,32'h80,CF,I1, DB};
      vecs[15] = '{1'b1,1'b1,1'b1,32'h80,CF,1'b1,32'h11111111, 1'b1,1'b1,1'b1,32'h80,CF,I1,DB};
      vecs[16] = '{1'b1,1'b0,1'b1,32'h80,Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h80,CF,I1, DB};
      vecs[17] = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h80,CF,I1, DB};
      vecs[18] = '{1'b0,1'b0,1'b0,Z,     Z,1'b1,32'hFFFFFFFF, 1'b0,1'b0,1'b0,32'h80,CF,I1,DB};
      vecs[19] = '{1'b0,1'b0,1'b0,Z,     Z,1'b0,Z,        1'b0,1'b0,1'b0,32'h80,CF,I1, DB};

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, Z);
      chk("rst_mem_wdata", mem_wdata, Z);
      chk("rst_instr", instr, NOP);
      chk("rst_data", data, Z);
      chk("rst_err", err, 1'b0);
      chk("rst_stall", stall, 1'b0);

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].fet, vecs[i].a, vecs[i].wd, vecs[i].ack, vecs[i].rdat);
         #1;
         chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
         chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
         chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
         chk($sformatf("v%0d_data", i), data, vecs[i].e_data);
         chk($sformatf("v%0d_err", i), err, 1'b0);
         @(negedge clk);
      end

      // Reset during a pending fetch, followed by a stale ack.
      drive(1'b1, 1'b0, 1'b1, 32'h20, Z, 1'b0, Z);
      @(negedge clk);
      #1;
      chk("rs_c1_mem_req", mem_req, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rs_c2_mem_req", mem_req, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 32'h99999999);
      #1;
      chk("rs_c3_mem_req", mem_req, 1'b0);
      chk("rs_c3_instr", instr, NOP);
      chk("rs_c3_data", data, Z);
      chk("rs_c3_stall", stall, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
      #1;
      chk("rs_c4_instr", instr, NOP);
      chk("rs_c4_data", data, Z);
      chk("rs_c4_mem_req", mem_req, 1'b0);
      chk("rs_c4_stall", stall, 1'b0);
      @(negedge clk);

`ifdef MEM_CTRL_TIMEOUT_EN
      // No ack: four cycles in READ, then ERR until reset.
      drive(1'b1, 1'b0, 1'b0, 32'h30, Z, 1'b0, Z);
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("to_c%0d_err", c), err, 1'b0);
         chk($sformatf("to_c%0d_mem_req", c), mem_req, 1'b1);
         chk($sformatf("to_c%0d_stall", c), stall, 1'b1);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
      for (int c = 5; c <= 8; c++) begin
         if (c == 7) mem_ack = 1'b1;
         else mem_ack = 1'b0;
         #1;
         chk($sformatf("to_c%0d_err", c), err, 1'b1);
         chk($sformatf("to_c%0d_mem_req", c), mem_req, 1'b0);
         chk($sformatf("to_c%0d_stall", c), stall, 1'b1);
         @(negedge clk);
      end
      mem_ack = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("to_rst_err", err, 1'b0);
      chk("to_rst_stall", stall, 1'b0);
      chk("to_rst_data", data, Z);
      @(negedge clk);
`else
      // Without the timeout an access waits indefinitely for its ack.
      drive(1'b1, 1'b0, 1'b0, 32'h60, Z, 1'b0, Z);
      @(negedge clk);
      repeat (10) @(negedge clk);
      #1;
      chk("wait_mem_req", mem_req, 1'b1);
      chk("wait_stall", stall, 1'b1);
      chk("wait_err", err, 1'b0);
      chk("wait_mem_addr", mem_addr, 32'h60);
      mem_ack = 1'b1;
      mem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
      #1;
      chk("wait_data", data, 32'h5A5A5A5A);
      chk("wait_instr", instr, NOP);
      chk("wait_done_stall", stall, 1'b0);
      @(negedge clk);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
